// File: rtl/mm_job_arbiter_if.sv
// mm_job_arbiter_if: one AXI-Stream link (valid/ready/data/last plus a one-bit owner id).
interface mm_job_arbiter_if #(parameter int W = 32);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tid;
    modport master (output tvalid, tdata, tlast, tid, input tready);
    modport slave (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/mm_job_arbiter.sv
// mm_job_arbiter: round-robin sharing of one matrix-multiply engine between two requesters.
module mm_job_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int N = 8
) (
    input  logic                   axis_aclk,
    input  logic                   axis_areset,
    mm_job_arbiter_if.slave        s0_axis,
    mm_job_arbiter_if.slave        s1_axis,
    mm_job_arbiter_if.master       m0_axis,
    mm_job_arbiter_if.slave        s2_axis,
    mm_job_arbiter_if.master       m1_axis,
    output logic [1:0]             state_debug,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, RET = 2'd2, BAD = 2'd3} state_t;
    localparam int CW = $clog2(2 * N * N);
    localparam logic [CW-1:0] JOB_LAST = CW'(2 * N * N - 1);
    localparam logic [CW-1:0] RES_LAST = CW'(N * N - 1);
    state_t state, state_nx;
    logic grant, last_grant, pick, any_req;
    logic [CW-1:0] cnt;
    logic fwd, ret, g_valid, g_last, fire_f, fire_r, job_end, res_end;
    logic [C_AXIS_TDATA_WIDTH-1:0] g_data;
    assign fwd = state == FWD;
    assign ret = state == RET;
    assign any_req = s0_axis.tvalid | s1_axis.tvalid;
    assign pick = (s0_axis.tvalid & s1_axis.tvalid) ? ~last_grant : s1_axis.tvalid;
    assign g_valid = grant ? s1_axis.tvalid : s0_axis.tvalid;
    assign g_last = grant ? s1_axis.tlast : s0_axis.tlast;
    assign g_data = grant ? s1_axis.tdata : s0_axis.tdata;
    assign m0_axis.tvalid = fwd & g_valid;
    assign m0_axis.tdata = g_data;
    assign m0_axis.tlast = fwd & (cnt == JOB_LAST);
    assign m0_axis.tid = 1'b0;
    assign s0_axis.tready = fwd & ~grant & m0_axis.tready;
    assign s1_axis.tready = fwd & grant & m0_axis.tready;
    assign s2_axis.tready = ret & m1_axis.tready;
    assign m1_axis.tvalid = ret & s2_axis.tvalid;
    assign m1_axis.tdata = s2_axis.tdata;
    assign m1_axis.tlast = ret & (cnt == RES_LAST);
    assign m1_axis.tid = ret & grant;
    assign fire_f = m0_axis.tvalid & m0_axis.tready;
    assign fire_r = m1_axis.tvalid & m1_axis.tready;
    assign job_end = fire_f & (cnt == JOB_LAST);
    assign res_end = fire_r & (cnt == RES_LAST);
    assign state_debug = state;
    // next state: a job is granted, forwarded in full, then its results returned
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE: state_nx = any_req ? FWD : IDLE;
            FWD: state_nx = job_end ? RET : FWD;
            RET: state_nx = res_end ? IDLE : RET;
            default: state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) state <= IDLE;
        else state <= state_nx;
    end
    // grant, beat counter shared by both phases, round-robin history and sticky framing error
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            cnt <= '0;
            grant <= 1'b0;
            last_grant <= 1'b1;
            err <= 1'b0;
        end else begin
            if (state == IDLE && any_req) grant <= pick;
            if (fire_f | fire_r) cnt <= (job_end | res_end) ? '0 : cnt + CW'(1);
            if (fire_f && (g_last != (cnt == JOB_LAST))) err <= 1'b1;
            if (res_end) last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_mm_job_arbiter.sv
// tb_mm_job_arbiter: directed jobs with a scoreboard of expected engine-side and result-side beats.
module tb_mm_job_arbiter;
    localparam int W = 32;
    localparam int N = 2;
    localparam int B = 2 * N * N;
    localparam int R = N * N;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_debug;
    logic err;
    always #5 clk = ~clk;
    mm_job_arbiter_if #(.W(W)) s0 ();
    mm_job_arbiter_if #(.W(W)) s1 ();
    mm_job_arbiter_if #(.W(W)) m0 ();
    mm_job_arbiter_if #(.W(W)) s2 ();
    mm_job_arbiter_if #(.W(W)) m1 ();
    mm_job_arbiter #(.C_AXIS_TDATA_WIDTH(W), .N(N)) dut (
        .axis_aclk(clk), .axis_areset(rst),
        .s0_axis(s0), .s1_axis(s1), .m0_axis(m0), .s2_axis(s2), .m1_axis(m1),
        .state_debug(state_debug), .err(err)
    );
    int n_chk = 0;
    int n_pass = 0;
    logic [W:0] exp_m0[$];
    logic [W+1:0] exp_m1[$];
    int jobs[2], beat[2], sjob[2], qjob[2], bad[2];
    int res_idx = 0;
    int eres = 0;
    int m0_cnt = 0;
    bit res_en = 0;
    bit m0_tog = 0;
    bit m1_tog = 0;
    bit err_m = 0;
    function automatic logic [W-1:0] sdat(int r, int j, int b);
        return W'(32'h1000_0000 | (r << 24) | (j << 8) | b);
    endfunction
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic drive();
        s0.tvalid = jobs[0] > 0;
        s0.tdata = sdat(0, sjob[0], beat[0]);
        s0.tlast = (beat[0] == B - 1) ^ (beat[0] == bad[0]);
        s1.tvalid = jobs[1] > 0;
        s1.tdata = sdat(1, sjob[1], beat[1]);
        s1.tlast = (beat[1] == B - 1) ^ (beat[1] == bad[1]);
        s2.tvalid = res_en;
        s2.tdata = W'(32'hC000_0000 + res_idx);
        s2.tlast = (res_idx % R) == R - 1;
    endtask
    task automatic push_job(int r);
        for (int b = 0; b < B; b++) exp_m0.push_back({b == B - 1, sdat(r, qjob[r], b)});
        qjob[r]++;
        for (int k = 0; k < R; k++) begin
            exp_m1.push_back({1'(r), k == R - 1, W'(32'hC000_0000 + eres)});
            eres++;
        end
    endtask
    task automatic advance(int r);
        if (beat[r] == bad[r]) err_m = 1;
        beat[r]++;
        if (beat[r] == B) begin
            beat[r] = 0;
            jobs[r]--;
            sjob[r]++;
            bad[r] = -1;
        end
    endtask
    task automatic step();
        logic f0, f1, fm0, fm1, fs2;
        logic [W:0] e0;
        logic [W+1:0] e1;
        @(negedge clk);
        f0 = s0.tvalid && s0.tready;
        f1 = s1.tvalid && s1.tready;
        fm0 = m0.tvalid && m0.tready;
        fm1 = m1.tvalid && m1.tready;
        fs2 = s2.tvalid && s2.tready;
        if (fm0) begin
            m0_cnt++;
            e0 = exp_m0.size() == 0 ? 'x : exp_m0.pop_front();
            chk("m0_beat", {m0.tlast, m0.tdata}, e0);
        end
        if (fm1) begin
            e1 = exp_m1.size() == 0 ? 'x : exp_m1.pop_front();
            chk("m1_beat", {m1.tid, m1.tlast, m1.tdata}, e1);
        end
        if (state_debug != 2'd2 && s2.tvalid) chk("s2_held_outside_ret", {s2.tready, m1.tvalid}, 0);
        chk("err_flag", err, err_m);
        @(posedge clk);
        #1;
        if (f0) advance(0);
        if (f1) advance(1);
        if (fs2) res_idx++;
        if (m0_tog) m0.tready = ~m0.tready;
        if (m1_tog) m1.tready = ~m1.tready;
        drive();
    endtask
    task automatic run_idle(int budget);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = exp_m0.size() == 0 && exp_m1.size() == 0 && state_debug == 2'd0;
        end
        chk("job_done_in_budget", done, 1);
    endtask
    task automatic do_reset(int ncyc);
        rst = 1;
        err_m = 0;
        m0_tog = 0;
        m1_tog = 0;
        m0.tready = 1;
        m1.tready = 1;
        drive();
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_state", state_debug, 0);
        chk("rst_err", err, 0);
        chk("rst_readys", {s0.tready, s1.tready, s2.tready}, 0);
        chk("rst_valids", {m0.tvalid, m1.tvalid}, 0);
        chk("rst_lasts_tid", {m0.tlast, m1.tlast, m1.tid}, 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        int n;
        s0.tid = 0;
        s1.tid = 0;
        s2.tid = 0;
        for (int r = 0; r < 2; r++) begin
            jobs[r] = 0;
            beat[r] = 0;
            sjob[r] = 0;
            qjob[r] = 0;
            bad[r] = -1;
        end
        do_reset(2);
        res_en = 1;
        jobs[0] = 1;
        push_job(0);
        drive();
        run_idle(200);
        chk("single_job_err", err, 0);
        do_reset(1);
        jobs[0] = 2;
        jobs[1] = 1;
        push_job(0);
        push_job(1);
        push_job(0);
        drive();
        run_idle(400);
        m0_tog = 1;
        m1_tog = 1;
        m0_cnt = 0;
        jobs[0] = 1;
        push_job(0);
        drive();
        run_idle(400);
        chk("toggle_beat_count", m0_cnt, B);
        m0_tog = 0;
        m1_tog = 0;
        m0.tready = 1;
        m1.tready = 1;
        bad[0] = 3;
        jobs[0] = 1;
        push_job(0);
        drive();
        run_idle(200);
        chk("err_after_bad_tlast", err, 1);
        repeat (4) step();
        m0_cnt = 0;
        jobs[0] = 1;
        push_job(0);
        drive();
        n = 0;
        while (m0_cnt < 5 && n < 100) begin
            step();
            n++;
        end
        chk("five_beats_before_reset", m0_cnt, 5);
        jobs[0] = 0;
        beat[0] = 0;
        sjob[0]++;
        qjob[0] = sjob[0];
        exp_m0.delete();
        exp_m1.delete();
        eres = res_idx;
        do_reset(1);
        jobs[1] = 1;
        push_job(1);
        drive();
        run_idle(200);
        chk("err_after_fresh_job", err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
